// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the memory request/response channel, the redirect inputs and the
//   decode-side handshake of the instruction prefetch queue.
//   master : the prefetch queue (drives requests and the decode head entry)
//   slave  : the environment (memory, branch resolution and decode)
//
//   imem_req/imem_addr     request strobe and address (queue -> memory)
//   imem_valid/imem_rdata  in-order response strobe and word (memory -> queue)
//   redirect/redirect_pc   flush and restart address (branch unit -> queue)
//   instr_valid/instr/instr_pc  head entry (queue -> decode)
//   instr_ready            decode accepts the head entry
//   count                  current FIFO occupancy
interface fetch_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_valid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;
  logic [CNT_W-1:0]      count;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata,
    input  redirect, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    output count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata,
    output redirect, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    input  count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction prefetch queue between instruction memory and decode.
//   Generates sequential fetch addresses, keeps at most one memory request
//   in flight and buffers returned words with their PCs in a DEPTH-entry
//   FIFO. A redirect flushes the FIFO and restarts fetch at the new PC.
//
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : fetch_queue_if.master (memory channel, redirect, decode head)
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

  // Control state
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  outstanding_q, outstanding_d;
  logic                  drop_q, drop_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Data state (no reset needed: only read when count says the slot is live)
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [DATA_WIDTH-1:0] word_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

  logic                  resp;
  logic                  accept;
  logic                  issue;
  logic                  deq;
  logic [CNT_W:0]        occ_after_accept;
  logic                  unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  always_comb begin
    resp   = bus.imem_valid && outstanding_q;
    accept = resp && !drop_q && !bus.redirect;
    // The slot for a response landing this cycle is reserved before a new
    // request may go out, so the FIFO can never overflow. Dequeues are not
    // credited here.
    occ_after_accept = {1'b0, count_q} + {{CNT_W{1'b0}}, accept};
    issue  = !rst && !bus.redirect && (!outstanding_q || bus.imem_valid) &&
             (occ_after_accept < DEPTH_C);
    deq    = (count_q != '0) && bus.instr_ready && !bus.redirect;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (bus.redirect) begin
      fetch_pc_d    = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      // A response in this cycle is simply discarded; only a request still
      // in flight after this edge needs its future response dropped.
      outstanding_d = outstanding_q && !bus.imem_valid;
      drop_d        = outstanding_q && !bus.imem_valid;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(4);
        req_pc_d      = fetch_pc_q;
        outstanding_d = 1'b1;
      end else if (resp) begin
        outstanding_d = 1'b0;
      end

      if (resp) begin
        drop_d = 1'b0;
      end

      if (accept) begin
        tail_d = tail_q + PTR_W'(1);
      end

      if (deq) begin
        head_d = head_q + PTR_W'(1);
      end

      case ({accept, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
    if (accept && !rst) begin
      word_mem[tail_q] <= bus.imem_rdata;
      pc_mem[tail_q]   <= req_pc_q;
    end
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.count       = count_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = (count_q != '0) ? word_mem[head_q] : '0;
  assign bus.instr_pc    = (count_q != '0) ? pc_mem[head_q]   : '0;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch queue for the pipelined core generation. It sits between instruction memory and decode, replacing the single-cycle fetch path in which the PC drives memory directly. It generates sequential fetch addresses and issues in-order memory requests, at most one outstanding. Returned words are buffered with their PCs in a DEPTH-entry FIFO, and the queue is flushed and restarted on a redirect from branch or jump resolution.

## Interface
- DATA_WIDTH, 32, instruction/data word width
- ADDR_WIDTH, 32, PC and memory address width
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  request strobe, one cycle per request
- imem_addr  out  ADDR_WIDTH  request address, valid with imem_req
- imem_valid  in  1  response strobe; responses are in order
- imem_rdata  in  DATA_WIDTH  response word, valid with imem_valid
- redirect  in  1  flush queue and restart fetch
- redirect_pc  in  ADDR_WIDTH  new fetch address; bits [1:0] are ignored and treated as 0
- instr_valid  out  1  head entry present
- instr  out  DATA_WIDTH  head instruction
- instr_pc  out  ADDR_WIDTH  PC of head instruction
- instr_ready  in  1  decode accepts head
- count  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- State:
  - fetch_pc register, reset to RESET_PC.
  - outstanding flag.
  - drop flag.
  - FIFO of {pc, word} with head/tail pointers.
  - count.
- Issue:
  - imem_req = !rst && !redirect && (!outstanding || imem_valid) && (count + accept) < DEPTH, where accept = imem_valid && outstanding && !drop && !redirect.
  - imem_addr = fetch_pc, driven combinationally from the register.
  - On issue: fetch_pc += 4, modulo 2^ADDR_WIDTH (wraps silently); outstanding set.
- Response, when imem_valid && outstanding:
  - If drop: discard the word and clear drop.
  - Else if !redirect: write {pc of request, imem_rdata} at tail; count increments.
  - outstanding clears unless a new request issues in the same cycle.
  - imem_valid with outstanding = 0 is ignored.
- Dequeue:
  - Occurs when instr_valid && instr_ready && !redirect; head advances and count decrements.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - A dequeue does not free space for an issue in the same cycle; the issue check uses the pre-dequeue count.
- Outputs:
  - instr_valid = (count != 0).
  - When instr_valid = 1, instr/instr_pc = head entry.
  - When instr_valid = 0, instr/instr_pc = 0.
- Redirect has the highest priority:
  - Pointers and count go to 0.
  - fetch_pc ← {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - No issue in the redirect cycle.
  - If outstanding and no response this cycle: drop is set, so the next response is discarded.
  - If a response arrives in the redirect cycle: it is discarded, and drop stays clear.
  - A handshake in the redirect cycle is void; decode must ignore that instr.
- Overflow is impossible by construction because the issue check reserves a slot for the outstanding response.
- Reset:
  - Clears outstanding, drop, pointers and count.
  - Sets fetch_pc = RESET_PC.
  - Applying rst mid-operation behaves identically, and any pending response is ignored because outstanding = 0.

## Timing
- Reset values of all outputs: imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0, count = 0.
- First imem_req occurs in the first cycle with rst low.
- Response to visibility:
  - A word accepted at edge N is visible on instr/instr_valid after that edge, i.e. in cycle N+1.
  - There is no combinational bypass from imem_rdata to instr.
- Throughput: with a memory that responds the cycle after the request and decode always ready, one instruction per cycle is sustained.
- Redirect to first request: the request at redirect_pc issues the cycle after redirect. With 1-cycle memory, instr_valid rises 2 cycles after that request.

## Test plan
- Reset, 1-cycle memory returning addr as data, instr_ready = 1 → imem_req in the first cycle after reset at 0x0. instr_valid and instr_pc step 0x0, 0x4, 0x8… on consecutive cycles, with instr = instr_pc.
- instr_ready = 0, DEPTH = 4 → count reaches 4 and imem_req stays low. Asserting ready for 1 cycle dequeues PC 0x0, and exactly one new request issues the following cycle.
- Memory with 3-cycle latency; redirect to 0x100 one cycle after issue → old response discarded, count = 0. The next accepted entry has instr_pc = 0x100.
- Redirect to 0x203 in the same cycle as a response → response discarded, drop stays clear. The next request goes to 0x200 and the next response is enqueued.
- RESET_PC = 0xFFFFFFF8 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (wrap).
- rst asserted with 2 entries queued and one request outstanding → after reset count = 0 and the late response is ignored. Fetch restarts at RESET_PC.
